// File: rtl/condicionador_entradas.sv
// Input conditioning for the slide switches and the start push-button:
// two-flop synchronizers, per-bit debounce and a press/release FSM for start.
module condicionador_entradas #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] chave_raw,
    input  logic       start_raw_n,
    output logic [3:0] chave,
    output logic       start,
    output logic       start_pulse,
    output logic       chave_changed
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("DEBOUNCE_CYCLES must be at least 2");
        end
    endgenerate

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Bit 4 carries the button, already inverted so that 1 means pressed.
    logic [4:0] raw_w;
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;

    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    chave_q;
    logic [3:0]    chave_d;
    logic          changed_q;
    logic          changed_d;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] scnt_q;
    logic [CW-1:0] scnt_d;
    logic          start_q;
    logic          start_d;
    logic          pulse_q;
    logic          pulse_d;
    logic          press_s;

    assign raw_w   = {~start_raw_n, chave_raw};
    assign press_s = sync2_q[4];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
        end
    end

    // Switch debounce: count only while the synchronized level disagrees with
    // the accepted one; any agreement restarts the count.
    always_comb begin
        chave_d = chave_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != chave_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    chave_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        changed_d = (chave_d != chave_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            chave_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            chave_q   <= chave_d;
            changed_q <= changed_d;
        end
    end

    // The first disagreeing cycle leaves IDLE/PRESSED with the count already at 1,
    // keeping the button latency identical to the switch bits.
    always_comb begin
        state_d = state_q;
        scnt_d  = '0;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_s) begin
                    state_d = PRESS_WAIT;
                    scnt_d  = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!press_s) begin
                    state_d = IDLE;
                end else if (scnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    scnt_d = scnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!press_s) begin
                    state_d = RELEASE_WAIT;
                    scnt_d  = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (press_s) begin
                    state_d = PRESSED;
                end else if (scnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    scnt_d = scnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            start_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            start_q <= start_d;
            pulse_q <= pulse_d;
        end
    end

    assign chave         = chave_q;
    assign chave_changed = changed_q;
    assign start         = start_q;
    assign start_pulse   = pulse_q;

endmodule
